// File: rtl/eth_reg_arbiter.sv
// Register-bus arbiter: init master until init_done, then irq > tx/rx round-robin ownership.
// One-cycle request-to-grant; owner holds until release (deferred while reg_busy) or timeout, then a fixed idle gap.
module eth_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic       clk40m,
  input  logic       RSTN,
  input  logic       init_done,
  input  logic       tx_req,
  input  logic       rx_req,
  input  logic       irq_req,
  input  logic       tx_rel,
  input  logic       rx_rel,
  input  logic       irq_rel,
  input  logic       reg_busy,
  input  logic       err_clr,
  output logic [2:0] grant,
  output logic [1:0] reg_master,
  output logic       timeout_err,
  output logic [1:0] arb_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_IDLE  = 2'b01,
    ST_GRANT = 2'b10,
    ST_GAP   = 2'b11
  } state_t;

  localparam logic [1:0]  SEL_INIT  = 2'b00;
  localparam logic [1:0]  SEL_TX    = 2'b01;
  localparam logic [1:0]  SEL_RX    = 2'b10;
  localparam logic [1:0]  SEL_IRQ   = 2'b11;
  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  gap_q, gap_d;
  logic        pend_q, pend_d;
  logic        last_rx_q, last_rx_d;
  logic        own_rel;
  logic        set_err;
  logic [2:0]  grant_d;
  logic [1:0]  master_d;

  // owner_q reuses the reg_master encoding, so 11 means the irq master
  always_comb begin
    own_rel = ((owner_q == SEL_TX)  && tx_rel) ||
              ((owner_q == SEL_RX)  && rx_rel) ||
              ((owner_q == SEL_IRQ) && irq_rel);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    pend_d    = pend_q;
    last_rx_d = last_rx_q;
    set_err   = 1'b0;

    if (state_q != ST_INIT && !init_done) begin
      state_d = ST_INIT;
      hold_d  = '0;
      gap_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_done) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (!reg_busy && (irq_req || tx_req || rx_req)) begin
            state_d = ST_GRANT;
            hold_d  = '0;
            pend_d  = 1'b0;
            if (irq_req) begin
              owner_d = SEL_IRQ;
            end else if (tx_req && (!rx_req || last_rx_q)) begin
              owner_d   = SEL_TX;
              last_rx_d = 1'b0;
            end else begin
              owner_d   = SEL_RX;
              last_rx_d = 1'b1;
            end
          end
        end
        ST_GRANT: begin
          if ((own_rel || pend_q) && !reg_busy) begin
            state_d = ST_GAP;
            gap_d   = '0;
            pend_d  = 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            // a stuck owner is evicted even with a transaction in flight
            state_d = ST_GAP;
            gap_d   = '0;
            pend_d  = 1'b0;
            set_err = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
            if (own_rel) pend_d = 1'b1;
          end
        end
        default: begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    grant_d  = 3'b000;
    master_d = SEL_IRQ;
    case (state_d)
      ST_INIT:  master_d = SEL_INIT;
      ST_GRANT: begin
        master_d = owner_d;
        case (owner_d)
          SEL_TX:  grant_d = 3'b001;
          SEL_RX:  grant_d = 3'b010;
          default: grant_d = 3'b100;
        endcase
      end
      default:  master_d = SEL_IRQ;
    endcase
  end

  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_INIT;
      owner_q     <= SEL_INIT;
      hold_q      <= '0;
      gap_q       <= '0;
      pend_q      <= 1'b0;
      last_rx_q   <= 1'b1;
      grant       <= 3'b000;
      reg_master  <= SEL_INIT;
      arb_state   <= ST_INIT;
      timeout_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      last_rx_q  <= last_rx_d;
      grant      <= grant_d;
      reg_master <= master_d;
      arb_state  <= state_d;
      if (set_err)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/eth_reg_arbiter.md
ETH_REG_ARBITER -- requirements
Module: eth_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40000, maximum GRANT cycles per ownership (1 ms at 40 MHz); legal range 2..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles inserted between ownerships; legal range 1..15.
REQ-003 SHALL have port clk40m  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port init_done  in  1  initialization sequencer finished; while 0 the init master owns the register bus.
REQ-006 SHALL have ports tx_req, rx_req, irq_req  in  1 each  level requests from transmit, receive and interrupt-service masters.
REQ-007 SHALL have ports tx_rel, rx_rel, irq_rel  in  1 each  single-cycle release pulses from the same masters.
REQ-008 SHALL have port reg_busy  in  1  register I/O engine mid-transaction (engine state not idle).
REQ-009 SHALL have port err_clr  in  1  clears timeout_err.
REQ-010 SHALL have port grant  out  3  one-hot {irq,rx,tx} ownership.
REQ-011 SHALL have port reg_master  out  2  mux select: 00 init, 01 tx, 10 rx, 11 idle/irq.
REQ-012 SHALL have port timeout_err  out  1  sticky ownership-timeout flag.
REQ-013 SHALL have port arb_state  out  2  current state: 00 INIT, 01 IDLE, 10 GRANT, 11 GAP.

Function
REQ-014 SHALL implement states INIT, IDLE, GRANT, GAP; all outputs registered.
REQ-015 INIT: grant=000, reg_master=00; init_done sampled 1 -> IDLE next cycle.
REQ-016 IDLE: grant=000, reg_master=11; when reg_busy=0 and any request is high, SHALL select a winner and enter GRANT next cycle, grant and reg_master valid in that same cycle (request sampled cycle N -> grant at N+1).
REQ-017 Priority: irq_req highest; tx_req versus rx_req round-robin, the one not served last wins a tie; last_served updated on each tx/rx grant only.
REQ-018 reg_busy=1 in IDLE SHALL block new grants (stay IDLE).
REQ-019 GRANT: grant/reg_master held constant; reg_master = 01 tx, 10 rx, 11 irq.
REQ-020 Owner rel pulse with reg_busy=0 -> GAP next cycle; with reg_busy=1 SHALL latch pending_rel and enter GAP the cycle after reg_busy is first sampled 0.
REQ-021 rel pulses from non-owners, and in non-GRANT states, SHALL be ignored.
REQ-022 16-bit hold counter cleared on GRANT entry, increments each GRANT cycle; when it equals TIMEOUT_CYCLES-1 and no release occurs, SHALL force GAP next cycle and set timeout_err, regardless of reg_busy.
REQ-023 GAP: grant=000, reg_master=11 for exactly GAP_CYCLES cycles, then IDLE; requests during GAP wait and are arbitrated in IDLE.
REQ-024 Release and new request in same cycle: GAP still applied in full.
REQ-025 init_done sampled 0 in IDLE/GRANT/GAP -> INIT next cycle, grant dropped, counters and pending_rel cleared, timeout_err and last_served retained.
REQ-026 err_clr clears timeout_err next cycle; simultaneous set and clear: set wins.
REQ-027 grant SHALL never have more than one bit set; grant=000 whenever state is not GRANT.

Reset
REQ-028 RSTN low SHALL immediately force state INIT, grant=000, reg_master=00, timeout_err=0, arb_state=00, counters 0, pending_rel=0, last_served=rx (tx wins first tie).
REQ-029 Reset mid-GRANT SHALL drop grant asynchronously with no release required.
REQ-030 After RSTN rises, first state change no earlier than the first rising clk40m edge.

Verification
REQ-031 Reset, init_done=0 for 100 cycles, then 1 -> reg_master 00 throughout, IDLE/11 one cycle after init_done sampled.
REQ-032 tx_req and rx_req both high from IDLE -> tx granted (001, 01); tx_rel -> 2 GAP cycles -> rx granted (010, 10); repeat -> tx next.
REQ-033 irq_req, tx_req, rx_req all high -> irq granted first (100, 11); after release, tx then rx.
REQ-034 tx owner pulses tx_rel while reg_busy=1 for 5 more cycles -> grant held until reg_busy=0, GAP next cycle; rx_rel during tx grant ignored.
REQ-035 TIMEOUT_CYCLES=10, owner never releases -> GAP after exactly 10 GRANT cycles, timeout_err=1 sticky; err_clr pulse -> 0.
REQ-036 RSTN asserted mid-GRANT and init_done dropped mid-GRANT -> grant=000 immediately / next cycle respectively, state INIT.
